// File: rtl/hazard_if.sv
// Hazard-controller bundle: decode/EX/MEM/WB hazard inputs and pipeline control outputs.
interface hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_pause;
  logic       id_halt;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_memtoreg;
  logic       ex_writesreg;
  logic       ex_redirect;
  logic [4:0] mem_rd;
  logic       mem_writesreg;
  logic [4:0] wb_rd;
  logic       wb_writesreg;
  logic       resume;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       halted;

  // Pipeline side: supplies register-use info, consumes controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_pause, id_halt,
    output ex_rs1, ex_rs2, ex_rd, ex_memtoreg, ex_writesreg, ex_redirect,
    output mem_rd, mem_writesreg, wb_rd, wb_writesreg, resume,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, halted
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_pause, id_halt,
    input  ex_rs1, ex_rs2, ex_rd, ex_memtoreg, ex_writesreg, ex_redirect,
    input  mem_rd, mem_writesreg, wb_rd, wb_writesreg, resume,
    output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, operand forwarding,
// and the drain/halt sequence for ECALL/EBREAK/FENCE. Controls are combinational
// from inputs and registered state so they act in the same cycle as the hazard.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic             skip_q, skip_d;

  logic             lu_c;
  logic             pz_c;
  logic             hold_c;
  logic             flush_d_c;
  logic             flush_e_c;
  logic             halted_c;

  // Forwarding source for one EX operand; MEM is younger so it wins, x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_wr,
                                         input logic [4:0] wb_rd,  input logic wb_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = 2'b10;
    else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // Hazard terms seen by the RUN state
  always_comb begin
    lu_c = bus.ex_memtoreg && bus.ex_writesreg && (bus.ex_rd != 5'd0) &&
           ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
            (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    pz_c = bus.id_pause && !skip_q;
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    skip_d      = skip_q;
    hold_c      = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;
    halted_c    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.ex_redirect) begin
          // Redirect squashes the wrong-path ID instruction, so lu/pz are moot
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (lu_c) begin
          hold_c    = 1'b1;
          flush_e_c = 1'b1;
        end else if (pz_c) begin
          hold_c      = 1'b1;
          flush_e_c   = 1'b1;
          state_d     = ST_DRAIN;
          cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
          halt_pend_d = bus.id_halt;
        end
        // Pausing instruction has left ID once stall_d drops
        if (!hold_c) skip_d = 1'b0;
      end

      ST_DRAIN: begin
        hold_c    = 1'b1;
        flush_e_c = 1'b1;
        if (cnt_q == '0) begin
          if (halt_pend_q) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HALT: begin
        hold_c    = 1'b1;
        flush_e_c = 1'b1;
        halted_c  = 1'b1;
        if (bus.resume) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
      skip_q      <= skip_d;
    end
  end

  assign bus.stall_f = hold_c;
  assign bus.stall_d = hold_c;
  assign bus.flush_d = flush_d_c;
  assign bus.flush_e = flush_e_c;
  assign bus.halted  = halted_c;
  assign bus.fwd_a   = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_writesreg,
                               bus.wb_rd, bus.wb_writesreg);
  assign bus.fwd_b   = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_writesreg,
                               bus.wb_rd, bus.wb_writesreg);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue scoreboard.
// Expected output word: {stall_f, stall_d, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0], halted}
module tb_hazard_ctrl;

  localparam logic [8:0] E_IDLE = 9'h000;
  localparam logic [8:0] E_STL  = 9'h1A0;  // stall_f, stall_d, flush_e
  localparam logic [8:0] E_RED  = 9'h060;  // flush_d, flush_e
  localparam logic [8:0] E_HLT  = 9'h1A1;  // stalls plus halted

  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  hazard_if bus ();

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  logic tb_busy;

  hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // EX holds only bubbles while draining or halted
  always @(negedge clk) begin
    if (tb_busy) begin
      assert (!bus.ex_redirect && !bus.ex_memtoreg)
        else $error("redirect/load driven during drain or halt");
    end
  end

  // Monitor: controls are presented every cycle; compare one expectation per cycle
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e,
             bus.fwd_a, bus.fwd_b, bus.halted};
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %03h expected %03h", e.name, act, e.val);
      end
    end
  end

  task automatic clear_inputs();
    bus.id_rs1        = 5'd0;
    bus.id_rs2        = 5'd0;
    bus.id_uses_rs1   = 1'b0;
    bus.id_uses_rs2   = 1'b0;
    bus.id_pause      = 1'b0;
    bus.id_halt       = 1'b0;
    bus.ex_rs1        = 5'd0;
    bus.ex_rs2        = 5'd0;
    bus.ex_rd         = 5'd0;
    bus.ex_memtoreg   = 1'b0;
    bus.ex_writesreg  = 1'b0;
    bus.ex_redirect   = 1'b0;
    bus.mem_rd        = 5'd0;
    bus.mem_writesreg = 1'b0;
    bus.wb_rd         = 5'd0;
    bus.wb_writesreg  = 1'b0;
    bus.resume        = 1'b0;
  endtask

  // Queue the expectation for the inputs just applied, then advance one cycle
  task automatic cyc(input string name, input logic [8:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    tb_busy = 1'b0;
    rst_n   = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset state
    cyc("reset", E_IDLE);
    rst_n = 1'b1;
    cyc("idle", E_IDLE);

    // Load-use on rs1, then bubble leaves EX
    bus.ex_rd = 5'd5; bus.ex_memtoreg = 1'b1; bus.ex_writesreg = 1'b1;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    cyc("lu_rs1", E_STL);
    clear_inputs();
    cyc("lu_after", E_IDLE);
    // Load to x0 is no hazard
    bus.ex_rd = 5'd0; bus.ex_memtoreg = 1'b1; bus.ex_writesreg = 1'b1;
    bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
    cyc("lu_x0", E_IDLE);
    // Load-use on rs2
    clear_inputs();
    bus.ex_rd = 5'd9; bus.ex_memtoreg = 1'b1; bus.ex_writesreg = 1'b1;
    bus.id_rs2 = 5'd9; bus.id_uses_rs2 = 1'b1;
    cyc("lu_rs2", E_STL);
    bus.id_uses_rs2 = 1'b0;
    cyc("lu_unused_src", E_IDLE);
    bus.id_uses_rs2 = 1'b1; bus.ex_memtoreg = 1'b0;
    cyc("lu_not_load", E_IDLE);
    clear_inputs();

    // Forwarding
    bus.mem_rd = 5'd3; bus.mem_writesreg = 1'b1; bus.wb_rd = 5'd7; bus.wb_writesreg = 1'b1;
    bus.ex_rs1 = 5'd3; bus.ex_rs2 = 5'd7;
    cyc("fwd_mem_wb", 9'h012);
    bus.wb_rd = 5'd3;
    cyc("fwd_mem_beats_wb", 9'h010);
    bus.mem_rd = 5'd0; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd0;
    cyc("fwd_x0_mem", 9'h002);
    bus.wb_rd = 5'd0; bus.ex_rs2 = 5'd0;
    cyc("fwd_x0_wb", E_IDLE);
    bus.mem_rd = 5'd7; bus.mem_writesreg = 1'b0; bus.wb_rd = 5'd7;
    bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7;
    cyc("fwd_mem_nowrite", 9'h00A);
    bus.mem_writesreg = 1'b1;
    cyc("fwd_both_mem", 9'h014);
    clear_inputs();

    // Redirect overrides simultaneous load-use and pause
    bus.ex_redirect = 1'b1;
    bus.ex_rd = 5'd5; bus.ex_memtoreg = 1'b1; bus.ex_writesreg = 1'b1;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1; bus.id_pause = 1'b1;
    cyc("redirect", E_RED);
    clear_inputs();
    cyc("redirect_stays_run", E_IDLE);

    // FENCE: 4 held cycles, then one free cycle with pause still high
    bus.id_pause = 1'b1; bus.id_halt = 1'b0;
    cyc("fence_detect", E_STL);
    tb_busy = 1'b1;
    bus.mem_rd = 5'd4; bus.mem_writesreg = 1'b1; bus.ex_rs1 = 5'd4;
    cyc("fence_drain1_fwd", 9'h1B0);
    bus.mem_rd = 5'd0; bus.mem_writesreg = 1'b0; bus.ex_rs1 = 5'd0;
    cyc("fence_drain2", E_STL);
    cyc("fence_drain3", E_STL);
    tb_busy = 1'b0;
    cyc("fence_skip", E_IDLE);
    bus.id_pause = 1'b0;
    cyc("fence_after", E_IDLE);

    // ECALL: resume during DRAIN (incl. DRAIN->HALT cycle) is ignored
    bus.id_pause = 1'b1; bus.id_halt = 1'b1;
    cyc("ecall_detect", E_STL);
    tb_busy = 1'b1;
    cyc("ecall_drain1", E_STL);
    bus.resume = 1'b1;
    cyc("ecall_drain2_resume", E_STL);
    cyc("ecall_drain3_resume", E_STL);
    bus.resume = 1'b0;
    cyc("ecall_halt1", E_HLT);
    cyc("ecall_halt2", E_HLT);
    bus.resume = 1'b1;
    cyc("ecall_halt_resume", E_HLT);
    bus.resume = 1'b0;
    tb_busy = 1'b0;
    cyc("ecall_released", E_IDLE);
    bus.id_pause = 1'b0; bus.id_halt = 1'b0;
    cyc("ecall_after", E_IDLE);

    // Asynchronous reset in the middle of DRAIN
    bus.id_pause = 1'b1;
    cyc("rst_detect", E_STL);
    tb_busy = 1'b1;
    cyc("rst_drain1", E_STL);
    bus.id_pause = 1'b0;
    rst_n = 1'b0;
    tb_busy = 1'b0;
    cyc("rst_async", E_IDLE);
    rst_n = 1'b1;
    cyc("rst_release1", E_IDLE);
    cyc("rst_release2", E_IDLE);

    // Drain remaining expectations with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It sits beside the decode stage and consumes the decoder's `pause` and register-use information. It drives the stall, flush and forwarding controls for the IF/ID/EX registers. It also owns the drain-and-halt sequence for ECALL/EBREAK/FENCE, holding the front end while older instructions retire.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles the front end is held so EX/MEM/WB empty; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  ID instruction actually reads that source.
- `id_pause`  in  1  decoder `pause` for the ID instruction.
- `id_halt`  in  1  with `id_pause`: 1 = ECALL/EBREAK (halt), 0 = FENCE (resume).
- `ex_rs1`, `ex_rs2`  in  5  source registers of the EX instruction.
- `ex_rd`  in  5  destination of the EX instruction.
- `ex_memtoreg`, `ex_writesreg`  in  1  EX instruction is a load / writes rd.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `mem_rd`  in  5  destination of the MEM instruction.
- `mem_writesreg`  in  1  MEM instruction writes rd.
- `wb_rd`  in  5  destination of the WB instruction.
- `wb_writesreg`  in  1  WB instruction writes rd.
- `resume`  in  1  single-cycle pulse that releases HALT.
- `stall_f`  out  1  hold PC.
- `stall_d`  out  1  hold IF/ID register.
- `flush_d`  out  1  bubble into IF/ID.
- `flush_e`  out  1  bubble into ID/EX.
- `fwd_a`, `fwd_b`  out  2  EX operand source: 00 regfile, 01 WB, 10 MEM.
- `halted`  out  1  FSM in HALT.

## Operation
State: FSM {RUN, DRAIN, HALT}, drain counter `cnt` of width $clog2(DRAIN_CYCLES+1), `halt_pend` bit, `skip` bit.

Hazard terms:
- `lu` = `ex_memtoreg & ex_writesreg & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- `pz` = `id_pause & !skip`.

RUN, priority high to low:
- `ex_redirect`: `flush_d=flush_e=1`, stalls 0. Cancels `lu` and `pz`. State stays RUN.
- `lu`: `stall_f=stall_d=flush_e=1` (one bubble).
- `pz`: `stall_f=stall_d=flush_e=1`. Next state DRAIN, `cnt<=DRAIN_CYCLES-1`, `halt_pend<=id_halt`.
- Otherwise all controls 0.
- `skip` clears on any RUN cycle with `stall_d=0`.

DRAIN:
- `stall_f=stall_d=flush_e=1`; `cnt` decrements each cycle.
- When `cnt==0`: next state is HALT if `halt_pend`, else RUN with `skip<=1`.

HALT:
- `stall_f=stall_d=flush_e=1`, `halted=1`.
- `resume` → RUN with `skip<=1`.

`skip` lets the pausing instruction leave ID exactly once as a no-op instead of re-triggering DRAIN.

`ex_redirect` and `lu` are ignored in DRAIN and HALT. They cannot legally occur there, since EX holds only bubbles; the bench asserts on this.

Forwarding is independent of FSM state (shown for `fwd_a`; `fwd_b` is the same using `ex_rs2`):
- `fwd_a=10` if `mem_writesreg & mem_rd!=0 & mem_rd==ex_rs1`.
- else `fwd_a=01` if `wb_writesreg & wb_rd!=0 & wb_rd==ex_rs1`.
- else `fwd_a=00`.
- MEM beats WB. Register x0 is never forwarded.

## Timing
- All outputs are combinational from inputs plus registered state; there is no output register.
- State, `cnt`, `halt_pend` and `skip` update on rising `clk`.
- Reset: state RUN, `cnt=0`, `halt_pend=0`, `skip=0`. With inputs low, every output is 0, including `halted=0`.
- Reset asserted mid-DRAIN or in HALT forces RUN immediately, asynchronously; outputs follow the same cycle.
- Pause latency: detection cycle (RUN, stalled) + `DRAIN_CYCLES` DRAIN cycles. FENCE then gives one RUN cycle with `stall_d=0`. Front end is held for exactly `DRAIN_CYCLES+1` cycles.
- Load-use costs exactly 1 cycle. Redirect costs 2 bubbles and 0 stall.
- `resume` in RUN or DRAIN is ignored. `resume` in the cycle DRAIN→HALT is ignored (HALT is entered).

## Test plan
- Load-use: `ex_rd=5`, `ex_memtoreg=ex_writesreg=1`, `id_rs1=5`, `id_uses_rs1=1` → `stall_f=stall_d=flush_e=1` for one cycle. Repeat with `ex_rd=0` → all 0.
- Forwarding: `mem_rd=wb_rd=3`, both write, `ex_rs1=3`, `ex_rs2=7`, `wb_rd` changed to 7 → `fwd_a=10`, `fwd_b=01`. Repeat with `mem_rd=0`, `ex_rs1=0` → `fwd_a=00`.
- Redirect with simultaneous `lu` and `pz` → `flush_d=flush_e=1`, `stall_f=0`, state stays RUN.
- FENCE with `DRAIN_CYCLES=3`, `id_pause` held high, `id_halt=0` → stall for 4 cycles, then 1 cycle all 0. No second DRAIN; `skip` clears.
- ECALL with `id_halt=1` → after 4 stalled cycles `halted=1` indefinitely. `resume` pulse → next cycle `halted=0` with `stall_d=0` for one cycle.
- `rst_n` low during DRAIN cycle 2 → outputs 0 immediately. After release, RUN with no residual stall.
